// File: rtl/mdu.sv
// mdu -- iterative multiply/divide unit with HI/LO result registers.
// One bit per RUN cycle: shift-add multiply, restoring shift-subtract divide,
// both on 32-bit magnitudes with sign correction on the RUN->DONE edge.
// Optional feature macro: MDU_DIV_EN compiles in the divider datapath.
// Without it, div/divu requests go straight to DONE and leave HI/LO alone.
// Handshake: start is sampled only in IDLE; busy covers RUN and DONE; done is
// a one-cycle pulse in DONE and dz is only meaningful while done is high.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic [31:0] dout,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_m;       // multiplicand / divisor magnitude
  logic [63:0] r_acc;     // {partial product, multiplier} or {remainder, quotient}
  logic [5:0]  r_cnt;
  logic        r_neg_q;   // negate product or quotient at the end
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;
`ifdef MDU_DIV_EN
  logic        r_is_div;
  logic        r_neg_r;   // remainder takes the dividend's sign
`endif

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_neg_q;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_step;
  logic [63:0] w_prod;
`ifdef MDU_DIV_EN
  logic        w_neg_r;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_sub;
  logic [63:0] w_div_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
`endif

  // Operand magnitudes and result signs; op[0]=0 selects the signed variants.
  always_comb begin
    w_a_mag = (!op[0] && a[31]) ? -a : a;
    w_b_mag = (!op[0] && b[31]) ? -b : b;
    w_neg_q = !op[0] && (a[31] ^ b[31]);
`ifdef MDU_DIV_EN
    w_neg_r = !op[0] && a[31];
`endif
  end

  // One iteration step plus the final sign-corrected results.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    w_prod     = r_neg_q ? -r_acc : r_acc;
`ifdef MDU_DIV_EN
    // The shifted remainder can reach 33 bits before the trial subtract.
    w_rem_sh   = r_acc[63:31];
    w_rem_sub  = w_rem_sh - {1'b0, r_m};
    w_div_next = w_rem_sub[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                               : {w_rem_sub[31:0], r_acc[30:0], 1'b1};
    w_step     = r_is_div ? w_div_next : w_mul_next;
    w_quo      = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
    w_rem      = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
`else
    w_step     = w_mul_next;
`endif
  end

  // Control FSM with registered status outputs and the iterative datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef MDU_DIV_EN
            r_m      <= w_b_mag;
            r_acc    <= {32'd0, w_a_mag};
            r_cnt    <= '0;
            r_neg_q  <= w_neg_q;
            r_is_div <= op[1];
            r_neg_r  <= w_neg_r;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
`else
            if (op[1]) begin
              // No divider: complete immediately with HI/LO untouched.
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_m     <= w_b_mag;
              r_acc   <= {32'd0, w_a_mag};
              r_cnt   <= '0;
              r_neg_q <= w_neg_q;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
`endif
          end
        end
        S_RUN: begin
          if (r_cnt == 6'd32) begin
`ifdef MDU_DIV_EN
            if (r_is_div) begin
              if (r_m == 32'd0) begin
                r_dz <= 1'b1;
              end else begin
                r_hi <= w_rem;
                r_lo <= w_quo;
              end
            end else begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
`else
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
`endif
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dout = rd_hi ? r_hi : r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed bench for mdu; the vector list adapts to MDU_DIV_EN.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_hi = 1'b0;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic        dz;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_lo = '0;

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd_hi (rd_hi),
    .dout  (dout),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Driver: issue one op, optionally re-pulse start mid-run, check the result
  // against the head of exp_q.
  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input int exp_lat, input logic exp_dz,
                        input int glitch_at);
    int lat;
    int busy_cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] exp_v;
    @(negedge clk);
    op = t_op; a = t_a; b = t_b; start = 1'b1; rd_hi = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~t_op; a = $urandom; b = $urandom;
    @(negedge clk);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (lat == 2) check({tag, " dout_during_run"}, dout, cur_lo);
      if (lat == glitch_at) begin
        start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat);
    check({tag, " busy_at_done"}, busy, 1'b1);
    check({tag, " dz"}, dz, exp_dz);
    rd_hi = 1'b1;
    #1 hi = dout;
    rd_hi = 1'b0;
    #1 lo = dout;
    exp_v = exp_q.pop_front();
    check({tag, " hi"}, hi, exp_v[63:32]);
    check({tag, " lo"}, lo, exp_v[31:0]);
    cur_lo = exp_v[31:0];
    @(negedge clk);
    check({tag, " done_cleared"}, done, 1'b0);
    check({tag, " dz_cleared"}, dz, 1'b0);
    check({tag, " busy_cleared"}, busy, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, " idle_no_requeue"}, busy, 1'b0);
    check({tag, " lo_held"}, dout, exp_v[31:0]);
  endtask

  // Reset asserted in the middle of a multiply aborts it without a done pulse.
  task automatic reset_mid_run();
    int seen;
    @(negedge clk);
    op = 2'b01; a = 32'd100; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid done", done, 1'b0);
    check("rst_mid dz", dz, 1'b0);
    check("rst_mid dout_lo", dout, 32'd0);
    rd_hi = 1'b1;
    #1 check("rst_mid dout_hi", dout, 32'd0);
    rd_hi = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cur_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("rst_mid no_done", seen, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dz", dz, 1'b0);
    rd_hi = 1'b1;
    #1 check("reset dout_hi", dout, 32'd0);
    rd_hi = 1'b0;
    #1 check("reset dout_lo", dout, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    exp_q.push_back(64'hFFFFFFFE_00000001);
    run_op("multu_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0, -1);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 33, 1'b0, -1);
    exp_q.push_back(64'h40000000_00000000);
    run_op("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 33, 1'b0, -1);
    exp_q.push_back(64'h00000001_00000000);
    run_op("multu_2p32", 2'b01, 32'h80000000, 32'h00000002, 33, 1'b0, -1);
`ifdef MDU_DIV_EN
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 33, 1'b0, -1);
    exp_q.push_back(64'h00000001_00000003);
    run_op("divu_10_3", 2'b11, 32'd10, 32'd3, 33, 1'b0, -1);
    exp_q.push_back(64'h00000001_00000003);
    run_op("divu_by0", 2'b11, 32'd10, 32'd0, 33, 1'b1, -1);
    exp_q.push_back(64'h00000000_80000000);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0, -1);
    exp_q.push_back(64'h00000002_FFFFFFF2);
    run_op("div_100_m7", 2'b10, 32'd100, 32'hFFFFFFF9, 33, 1'b0, -1);
    exp_q.push_back(64'h0000000F_0FFFFFFF);
    run_op("divu_ff_16", 2'b11, 32'hFFFFFFFF, 32'h00000010, 33, 1'b0, -1);
`else
    exp_q.push_back(64'h00000001_00000000);
    run_op("nodiv_div_8_2", 2'b10, 32'd8, 32'd2, 0, 1'b0, -1);
    exp_q.push_back(64'h00000001_00000000);
    run_op("nodiv_divu_8_0", 2'b11, 32'd8, 32'd0, 0, 1'b0, -1);
`endif
    exp_q.push_back(64'h00000000_0000002A);
    run_op("multu_glitch", 2'b01, 32'd6, 32'd7, 33, 1'b0, 5);

    reset_mid_run();

    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    run_op("post_rst_mult", 2'b00, 32'hFFFFFFFD, 32'h00000007, 33, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
